// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the fetch/sequencing path
package cpu_pkg;
  localparam int PC_WIDTH    = 10;
  localparam int INSTR_WIDTH = 16;

  localparam logic [15:0] INSTR_NOP  = 16'h0000;
  localparam logic [15:0] INSTR_HALT = 16'hFFFF;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    LOAD    = 2'd1,
    EXECUTE = 2'd2,
    HALT    = 2'd3
  } state_t;
endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - PC register with enable, branch load and wrapping increment
module program_counter
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc
);

  // Increment wraps naturally modulo 2^PC_WIDTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (en)
      pc <= load ? target : pc + PC_WIDTH'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch/load/execute sequencer owning the PC and instruction register
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                  PC_WIDTH    = cpu_pkg::PC_WIDTH,
  parameter int                  INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Stall,
  input  logic [INSTR_WIDTH-1:0] MemData,
  input  logic                   BranchTaken,
  input  logic [PC_WIDTH-1:0]    BranchTarget,
  output logic [PC_WIDTH-1:0]    MemAddr,
  output logic                   MemRead,
  output logic [INSTR_WIDTH-1:0] Opcode,
  output logic                   RegWrite,
  output logic [PC_WIDTH-1:0]    PcOut,
  output logic                   Halted
);

  localparam logic [INSTR_WIDTH-1:0] NOP_WORD  = INSTR_WIDTH'(INSTR_NOP);
  localparam logic [INSTR_WIDTH-1:0] HALT_WORD = INSTR_WIDTH'(INSTR_HALT);

  state_t                 state;
  logic [INSTR_WIDTH-1:0] ir;
  logic [PC_WIDTH-1:0]    pc;
  logic                   is_halt;
  logic                   is_nop;
  logic                   exec_go;

  assign is_halt = (ir == HALT_WORD);
  assign is_nop  = (ir == NOP_WORD);
  assign exec_go = (state == EXECUTE) && !Stall;

  program_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (Clk),
    .rst    (Reset),
    .en     (exec_go && !is_halt),
    .load   (BranchTaken),
    .target (BranchTarget),
    .pc     (pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= FETCH;
      ir    <= '0;
    end else begin
      case (state)
        FETCH:   if (!Stall) state <= LOAD;
        LOAD: begin
          ir    <= MemData;
          state <= EXECUTE;
        end
        EXECUTE: if (!Stall) state <= is_halt ? HALT : FETCH;
        HALT:    state <= HALT;
      endcase
    end
  end

  // Strobes are gated by Reset so they drop in the same instant reset rises
  assign MemRead  = (state == FETCH) && !Stall && !Reset;
  assign RegWrite = exec_go && !is_halt && !is_nop && !Reset;
  assign Halted   = (state == HALT);
  assign Opcode   = ir;
  assign MemAddr  = pc;
  assign PcOut    = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic [15:0] MemData;
  logic        BranchTaken = 1'b0;
  logic [9:0]  BranchTarget = '0;
  logic [9:0]  MemAddr;
  logic        MemRead;
  logic [15:0] Opcode;
  logic        RegWrite;
  logic [9:0]  PcOut;
  logic        Halted;

  fetch_unit dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Stall        (Stall),
    .MemData      (MemData),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .MemAddr      (MemAddr),
    .MemRead      (MemRead),
    .Opcode       (Opcode),
    .RegWrite     (RegWrite),
    .PcOut        (PcOut),
    .Halted       (Halted)
  );

  always #5 Clk = ~Clk;

  logic [15:0] mem [0:1023];
  int          rd6 = 0;

  // Synchronous instruction memory, one-cycle latency
  always @(posedge Clk) begin
    if (MemRead) begin
      MemData <= mem[MemAddr];
      if (MemAddr == 10'd6) rd6 <= rd6 + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rw_cnt = 0;
  int mr_cnt = 0;
  int mr_base = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    if (RegWrite) rw_cnt++;
    if (MemRead) mr_cnt++;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    Stall = 1'b0;
    BranchTaken = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc = 0;
    rw_cnt = 0;
    mr_cnt = 0;
    #1;
  endtask

  initial begin
    // Reset then linear run
    clear_mem();
    mem[0] = 16'h0123; mem[1] = 16'h0456; mem[2] = 16'h0789;
    mem[3] = 16'h0aaa; mem[4] = 16'h0bbb; mem[5] = 16'h0ccc;
    mem[6] = 16'h0ddd; mem[10'h100] = 16'h0eee;
    #2;
    check("rst_addr", MemAddr, 0);
    check("rst_opcode", Opcode, 0);
    check("rst_memread", MemRead, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_halted", Halted, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    check("lin_c0_addr", MemAddr, 0);
    check("lin_c0_memread", MemRead, 1);
    run_to(2);
    check("lin_c2_opcode", Opcode, 16'h0123);
    check("lin_c2_rw", RegWrite, 1);
    run_to(3);
    check("lin_c3_addr", MemAddr, 1);
    run_to(5);
    check("lin_c5_rw", RegWrite, 1);
    run_to(6);
    check("lin_c6_addr", MemAddr, 2);
    run_to(8);
    check("lin_c8_rw", RegWrite, 1);
    run_to(9);
    check("lin_pc_after", PcOut, 3);
    check("lin_rw_count", rw_cnt, 3);

    // Branch at PC=5
    run_to(17);
    check("br_pc", PcOut, 5);
    check("br_opcode", Opcode, 16'h0ccc);
    BranchTaken = 1'b1;
    BranchTarget = 10'h100;
    run_to(18);
    BranchTaken = 1'b0;
    #1;
    check("br_addr", MemAddr, 10'h100);
    check("br_memread", MemRead, 1);
    run_to(20);
    check("br_opcode_tgt", Opcode, 16'h0eee);
    check("br_no_read6", rd6, 0);

    // Stall: 2 cycles in FETCH, 3 in EXECUTE, one ignored in LOAD
    clear_mem();
    mem[0] = 16'h0abc;
    do_reset();
    Stall = 1'b1;
    #1;
    check("st_fetch_memread", MemRead, 0);
    run_to(2);
    Stall = 1'b0;
    #1;
    check("st_c2_memread", MemRead, 1);
    check("st_c2_addr", MemAddr, 0);
    run_to(3);
    Stall = 1'b1;
    run_to(4);
    check("st_load_ignored", Opcode, 16'h0abc);
    check("st_exec_rw", RegWrite, 0);
    run_to(7);
    Stall = 1'b0;
    #1;
    check("st_release_rw", RegWrite, 1);
    run_to(8);
    check("st_next_addr", MemAddr, 1);
    check("st_next_memread", MemRead, 1);
    check("st_rw_count", rw_cnt, 1);

    // NOP at 4, HALT at 5
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = 16'h1111;
    mem[4] = 16'h0000;
    mem[5] = 16'hFFFF;
    do_reset();
    run_to(14);
    check("nop_opcode", Opcode, 16'h0000);
    check("nop_rw", RegWrite, 0);
    run_to(15);
    check("halt_fetch_addr", MemAddr, 5);
    run_to(17);
    check("halt_opcode", Opcode, 16'hFFFF);
    check("halt_exec_rw", RegWrite, 0);
    check("halt_exec_halted", Halted, 0);
    run_to(18);
    check("halt_halted", Halted, 1);
    check("halt_pc", PcOut, 5);
    mr_base = mr_cnt;
    run_to(38);
    check("halt_memread_cnt", mr_cnt - mr_base, 0);
    check("halt_rw_count", rw_cnt, 4);
    check("halt_still", Halted, 1);
    check("halt_pc_hold", PcOut, 5);

    // Wrap from 10'h3FF
    clear_mem();
    mem[0] = 16'h0001;
    mem[10'h3FF] = 16'h2222;
    do_reset();
    run_to(2);
    BranchTaken = 1'b1;
    BranchTarget = 10'h3FF;
    run_to(3);
    BranchTaken = 1'b0;
    #1;
    check("wrap_tgt_addr", MemAddr, 10'h3FF);
    run_to(5);
    check("wrap_opcode", Opcode, 16'h2222);
    check("wrap_rw", RegWrite, 1);
    run_to(6);
    check("wrap_addr", MemAddr, 0);

    // Asynchronous reset mid-EXECUTE
    clear_mem();
    mem[0] = 16'h0123;
    mem[1] = 16'h0456;
    do_reset();
    run_to(5);
    check("ar_pre_opcode", Opcode, 16'h0456);
    check("ar_pre_rw", RegWrite, 1);
    check("ar_pre_pc", PcOut, 1);
    #3;
    Reset = 1'b1;
    #1;
    check("ar_rw", RegWrite, 0);
    check("ar_pc", PcOut, 0);
    check("ar_opcode", Opcode, 0);
    check("ar_memread", MemRead, 0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc = 0;
    #1;
    check("ar_resume_addr", MemAddr, 0);
    check("ar_resume_memread", MemRead, 1);
    run_to(2);
    check("ar_resume_opcode", Opcode, 16'h0123);
    check("ar_resume_rw", RegWrite, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
